// File: rtl/rgb_fader.sv
// ---------------------------------------------------------------------------
// rgb_fader
//
// Fades a three-channel 8-bit colour from its current value toward a target.
// The colour changes only at PWM cycle starts of the downstream RGB PWM
// controller. A rising edge on sync is one tick. Every STEP_DIV ticks, one
// fade step moves each channel toward its target by up to the latched step
// size. A channel never overshoots its target.
//
// Parameters
//   STEP_DIV        sync ticks per fade step (1..16)
//   INIT_R/G/B      colour loaded at reset
//
// Ports
//   clk                      clock, all logic on posedge
//   rst                      synchronous reset, active-low
//   sync                     PWM cycle-start strobe (may be several clks wide)
//   tgt_r/g/b[7:0]           target colour
//   step_i[3:0]              per-step increment (0 is treated as 1)
//   tgt_valid                target/step valid
//   tgt_ready                idle and out of reset, a new target can be taken
//   rcolor_o/gcolor_o/bcolor_o[7:0]  current colour to the PWM controller
//   busy                     fade in progress
//   done                     one-cycle pulse when the fade completes
// ---------------------------------------------------------------------------
module rgb_fader #(
   parameter int unsigned STEP_DIV = 4,
   parameter logic [7:0]  INIT_R   = 8'd0,
   parameter logic [7:0]  INIT_G   = 8'd0,
   parameter logic [7:0]  INIT_B   = 8'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sync,
   input  logic [7:0] tgt_r,
   input  logic [7:0] tgt_g,
   input  logic [7:0] tgt_b,
   input  logic [3:0] step_i,
   input  logic       tgt_valid,
   output logic       tgt_ready,
   output logic [7:0] rcolor_o,
   output logic [7:0] gcolor_o,
   output logic [7:0] bcolor_o,
   output logic       busy,
   output logic       done
);

   typedef enum logic {
      IDLE = 1'b0,
      FADE = 1'b1
   } state_e;

   localparam logic [3:0] DIV_LAST = 4'(STEP_DIV - 1);

   state_e     state_q, state_d;
   logic       sync_q;
   logic [3:0] div_cnt_q, div_cnt_d;
   logic [7:0] tgt_r_q, tgt_r_d;
   logic [7:0] tgt_g_q, tgt_g_d;
   logic [7:0] tgt_b_q, tgt_b_d;
   logic [3:0] step_q, step_d;
   logic [7:0] r_q, r_d;
   logic [7:0] g_q, g_d;
   logic [7:0] b_q, b_d;
   logic       done_q, done_d;

   logic       tick;
   logic       all_eq;
   logic       accept;

   // Moves one channel toward its target by at most step. The comparison
   // against the remaining distance clamps the result, so no wrap is possible.
   function automatic logic [7:0] fade_step(input logic [7:0] cur,
                                            input logic [7:0] tgt,
                                            input logic [3:0] step);
      logic [7:0] stp;
      stp = {4'd0, step};
      if (cur < tgt) begin
         if ((tgt - cur) <= stp) fade_step = tgt;
         else                    fade_step = cur + stp;
      end else if (cur > tgt) begin
         if ((cur - tgt) <= stp) fade_step = tgt;
         else                    fade_step = cur - stp;
      end else begin
         fade_step = cur;
      end
   endfunction

   // A sync held high for several clks yields a single tick.
   assign tick   = sync & ~sync_q;
   assign all_eq = (r_q == tgt_r_q) && (g_q == tgt_g_q) && (b_q == tgt_b_q);

   // Ready is masked by reset, so no accept can occur while rst is low.
   assign tgt_ready = (state_q == IDLE) && rst;
   assign busy      = (state_q == FADE);
   assign accept    = tgt_valid && tgt_ready;

   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      tgt_r_d   = tgt_r_q;
      tgt_g_d   = tgt_g_q;
      tgt_b_d   = tgt_b_q;
      step_d    = step_q;
      r_d       = r_q;
      g_d       = g_q;
      b_d       = b_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               tgt_r_d   = tgt_r;
               tgt_g_d   = tgt_g;
               tgt_b_d   = tgt_b;
               step_d    = (step_i == 4'd0) ? 4'd1 : step_i;
               div_cnt_d = 4'd0;
               state_d   = FADE;
            end
         end
         FADE: begin
            // Completion takes priority over a coincident tick: no step is
            // needed once every channel sits on its target.
            if (all_eq) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (tick) begin
               if (div_cnt_q == DIV_LAST) begin
                  div_cnt_d = 4'd0;
                  r_d       = fade_step(r_q, tgt_r_q, step_q);
                  g_d       = fade_step(g_q, tgt_g_q, step_q);
                  b_d       = fade_step(b_q, tgt_b_q, step_q);
               end else begin
                  div_cnt_d = div_cnt_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         sync_q    <= 1'b0;
         div_cnt_q <= 4'd0;
         tgt_r_q   <= INIT_R;
         tgt_g_q   <= INIT_G;
         tgt_b_q   <= INIT_B;
         step_q    <= 4'd1;
         r_q       <= INIT_R;
         g_q       <= INIT_G;
         b_q       <= INIT_B;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync;
         div_cnt_q <= div_cnt_d;
         tgt_r_q   <= tgt_r_d;
         tgt_g_q   <= tgt_g_d;
         tgt_b_q   <= tgt_b_d;
         step_q    <= step_d;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
         done_q    <= done_d;
      end
   end

   assign rcolor_o = r_q;
   assign gcolor_o = g_q;
   assign bcolor_o = b_q;
   assign done     = done_q;

endmodule

// File: tb/tb_rgb_fader.sv
// ---------------------------------------------------------------------------
// tb_rgb_fader
//
// Bench for rgb_fader with STEP_DIV=4 and INIT colour 0/0/0. The reference
// model counts the sync rising edges seen since an accept. From that count it
// derives the expected colour in closed form: each channel moves from its
// start colour toward the target by (ticks / STEP_DIV) * step, clamped at the
// target.
// ---------------------------------------------------------------------------
module tb_rgb_fader;

   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       sync;
   logic [7:0] tgt_r, tgt_g, tgt_b;
   logic [3:0] step_i;
   logic       tgt_valid;
   logic       tgt_ready;
   logic [7:0] rcolor_o, gcolor_o, bcolor_o;
   logic       busy;
   logic       done;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rgb_fader #(
      .STEP_DIV (SD),
      .INIT_R   (8'd0),
      .INIT_G   (8'd0),
      .INIT_B   (8'd0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sync      (sync),
      .tgt_r     (tgt_r),
      .tgt_g     (tgt_g),
      .tgt_b     (tgt_b),
      .step_i    (step_i),
      .tgt_valid (tgt_valid),
      .tgt_ready (tgt_ready),
      .rcolor_o  (rcolor_o),
      .gcolor_o  (gcolor_o),
      .bcolor_o  (bcolor_o),
      .busy      (busy),
      .done      (done)
   );

   // ---------------- reference model ----------------
   bit m_fade, m_done, m_psync;
   int m_ticks;
   int m_r, m_g, m_b;
   int m_sr, m_sg, m_sb;
   int m_tr, m_tg, m_tb;
   int m_step;

   function automatic int approach(int s, int t, int amt);
      if (s < t) return (t - s <= amt) ? t : s + amt;
      if (s > t) return (s - t <= amt) ? t : s - amt;
      return s;
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         m_fade <= 1'b0; m_done <= 1'b0; m_psync <= 1'b0; m_ticks <= 0;
         m_r <= 0; m_g <= 0; m_b <= 0;
         m_tr <= 0; m_tg <= 0; m_tb <= 0; m_step <= 1;
      end else begin
         m_psync <= sync;
         m_done  <= 1'b0;
         if (!m_fade) begin
            if (tgt_valid) begin
               m_fade  <= 1'b1;
               m_ticks <= 0;
               m_sr <= m_r; m_sg <= m_g; m_sb <= m_b;
               m_tr <= int'(tgt_r); m_tg <= int'(tgt_g); m_tb <= int'(tgt_b);
               m_step <= (step_i == 4'd0) ? 1 : int'(step_i);
            end
         end else if (m_r == m_tr && m_g == m_tg && m_b == m_tb) begin
            m_fade <= 1'b0;
            m_done <= 1'b1;
         end else if (sync && !m_psync) begin
            m_ticks <= m_ticks + 1;
            m_r <= approach(m_sr, m_tr, ((m_ticks + 1) / SD) * m_step);
            m_g <= approach(m_sg, m_tg, ((m_ticks + 1) / SD) * m_step);
            m_b <= approach(m_sb, m_tb, ((m_ticks + 1) / SD) * m_step);
         end
      end
   end

   function automatic logic [7:0] far_from(int cur);
      return (cur < 128) ? 8'(200 + $urandom_range(0, 55)) : 8'($urandom_range(0, 55));
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0; sync = 1'b1; tgt_valid = 1'b1;
      tgt_r = 8'd55; tgt_g = 8'd66; tgt_b = 8'd77; step_i = 4'd2;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_vec++;
         if ({rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done} !== 27'h0) begin
            n_err++;
            $display("FAIL reset_hold cyc=%0d got=%h exp=%h", c,
                     {rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done}, 27'h0);
         end
      end
      rst = 1'b1; tgt_valid = 1'b0; sync = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done} !== {24'h0, 3'b100}) begin
         n_err++;
         $display("FAIL reset_release got=%h exp=%h",
                  {rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done}, {24'h0, 3'b100});
      end
   endtask

   task automatic test_idle_sync();
      int dn = 0;
      for (int c = 0; c < 32; c++) begin
         sync = (c % 4 == 0);
         @(negedge clk);
         if (done === 1'b1) dn++;
         n_vec++;
         if ({rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done} !==
             {m_r[7:0], m_g[7:0], m_b[7:0], (!m_fade && rst), m_fade, m_done}) begin
            n_err++;
            $display("FAIL idle_sync cyc=%0d got=%h exp=%h", c,
                     {rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done},
                     {m_r[7:0], m_g[7:0], m_b[7:0], (!m_fade && rst), m_fade, m_done});
         end
      end
      n_vec++;
      if ({rcolor_o, gcolor_o, bcolor_o} !== 24'h0 || dn != 0 || tgt_ready !== 1'b1) begin
         n_err++;
         $display("FAIL idle_sync_end got rgb=%h done_cnt=%0d rdy=%b exp rgb=0 done_cnt=0 rdy=1",
                  {rcolor_o, gcolor_o, bcolor_o}, dn, tgt_ready);
      end
   endtask

   task automatic test_fade_basic();
      int rh[$];
      int exp_r[4] = '{3, 6, 9, 10};
      int bchg = 0;
      int cyc = 0;
      bit fin = 1'b0;
      logic [7:0] pr, pb;
      tgt_r = 8'd10; tgt_g = 8'd0; tgt_b = 8'd255; step_i = 4'd3;
      tgt_valid = 1'b1; sync = 1'b0;
      pr = rcolor_o; pb = bcolor_o;
      @(negedge clk);
      tgt_valid = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL basic_accept busy got=%b exp=1", busy);
      end
      while (!fin && cyc < 6000) begin
         sync = (cyc % 8 == 0);
         @(negedge clk);
         cyc++;
         n_vec++;
         if ({rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done} !==
             {m_r[7:0], m_g[7:0], m_b[7:0], (!m_fade && rst), m_fade, m_done}) begin
            n_err++;
            $display("FAIL basic_cycle cyc=%0d got=%h exp=%h", cyc,
                     {rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done},
                     {m_r[7:0], m_g[7:0], m_b[7:0], (!m_fade && rst), m_fade, m_done});
         end
         if (rcolor_o !== pr) rh.push_back(int'(rcolor_o));
         if (bcolor_o !== pb) bchg++;
         pr = rcolor_o; pb = bcolor_o;
         if (done === 1'b1) fin = 1'b1;
      end
      n_vec++;
      if (!fin) begin
         n_err++; $display("FAIL basic_timeout got no done exp done within 6000 clks");
      end
      n_vec++;
      if (rh.size() != 4) begin
         n_err++; $display("FAIL basic_r_seq_len got=%0d exp=4", rh.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rh[i] != exp_r[i]) begin
               n_err++; $display("FAIL basic_r_seq idx=%0d got=%0d exp=%0d", i, rh[i], exp_r[i]);
            end
         end
      end
      n_vec++;
      if (bchg != 85) begin
         n_err++; $display("FAIL basic_b_steps got=%0d exp=85", bchg);
      end
      n_vec++;
      if ({rcolor_o, gcolor_o, bcolor_o} !== {8'd10, 8'd0, 8'd255}) begin
         n_err++; $display("FAIL basic_final got=%h exp=%h", {rcolor_o, gcolor_o, bcolor_o},
                           {8'd10, 8'd0, 8'd255});
      end
   endtask

   task automatic test_step_zero();
      int rh[$];
      int steps = 0;
      int cyc = 0;
      bit fin = 1'b0;
      logic [23:0] prev;
      // move to 200/200/200 first
      tgt_r = 8'd200; tgt_g = 8'd200; tgt_b = 8'd200; step_i = 4'd15;
      tgt_valid = 1'b1; sync = 1'b0;
      @(negedge clk);
      tgt_valid = 1'b0;
      while (!fin && cyc < 6000) begin
         sync = (cyc % 6 == 0);
         @(negedge clk);
         cyc++;
         n_vec++;
         if ({rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done} !==
             {m_r[7:0], m_g[7:0], m_b[7:0], (!m_fade && rst), m_fade, m_done}) begin
            n_err++;
            $display("FAIL zero_pre cyc=%0d got=%h exp=%h", cyc,
                     {rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done},
                     {m_r[7:0], m_g[7:0], m_b[7:0], (!m_fade && rst), m_fade, m_done});
         end
         if (done === 1'b1) fin = 1'b1;
      end
      // step 0 is treated as 1
      tgt_r = 8'd198; tgt_g = 8'd205; tgt_b = 8'd200; step_i = 4'd0;
      tgt_valid = 1'b1; sync = 1'b0;
      prev = {rcolor_o, gcolor_o, bcolor_o};
      @(negedge clk);
      tgt_valid = 1'b0;
      fin = 1'b0; cyc = 0;
      while (!fin && cyc < 3000) begin
         sync = (cyc % 5 == 0);
         @(negedge clk);
         cyc++;
         n_vec++;
         if ({rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done} !==
             {m_r[7:0], m_g[7:0], m_b[7:0], (!m_fade && rst), m_fade, m_done}) begin
            n_err++;
            $display("FAIL zero_cycle cyc=%0d got=%h exp=%h", cyc,
                     {rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done},
                     {m_r[7:0], m_g[7:0], m_b[7:0], (!m_fade && rst), m_fade, m_done});
         end
         if ({rcolor_o, gcolor_o, bcolor_o} !== prev) steps++;
         if (rcolor_o !== prev[23:16]) rh.push_back(int'(rcolor_o));
         prev = {rcolor_o, gcolor_o, bcolor_o};
         if (done === 1'b1) fin = 1'b1;
      end
      n_vec++;
      if (!fin || steps != 5) begin
         n_err++; $display("FAIL zero_steps got fin=%0d steps=%0d exp fin=1 steps=5", fin, steps);
      end
      n_vec++;
      if (rh.size() != 2 || rh[0] != 199 || rh[1] != 198) begin
         n_err++; $display("FAIL zero_r_seq got size=%0d exp 199,198", rh.size());
      end
      n_vec++;
      if ({rcolor_o, gcolor_o, bcolor_o} !== {8'd198, 8'd205, 8'd200}) begin
         n_err++; $display("FAIL zero_final got=%h exp=%h", {rcolor_o, gcolor_o, bcolor_o},
                           {8'd198, 8'd205, 8'd200});
      end
   endtask

   task automatic test_equal_target();
      logic [23:0] cur;
      cur = {m_r[7:0], m_g[7:0], m_b[7:0]};
      sync = 1'b0;
      {tgt_r, tgt_g, tgt_b} = cur;
      step_i = 4'($urandom_range(0, 15));
      tgt_valid = 1'b1;
      @(negedge clk);
      tgt_valid = 1'b0;
      n_vec++;
      if ({busy, done} !== 2'b10) begin
         n_err++; $display("FAIL equal_n1 got busy/done=%b exp=10", {busy, done});
      end
      @(negedge clk);
      n_vec++;
      if ({busy, done, tgt_ready} !== 3'b011 || {rcolor_o, gcolor_o, bcolor_o} !== cur) begin
         n_err++; $display("FAIL equal_n2 got bdr=%b rgb=%h exp bdr=011 rgb=%h",
                           {busy, done, tgt_ready}, {rcolor_o, gcolor_o, bcolor_o}, cur);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0) begin
         n_err++; $display("FAIL equal_n3 done got=%b exp=0", done);
      end
   endtask

   task automatic test_held_sync();
      logic [7:0] tr, tg, tb;
      logic [23:0] prev;
      bit fin = 1'b0;
      bit rise, psync;
      int cyc = 0;
      tr = far_from(m_r);
      tg = 8'($urandom_range(0, 255));
      tb = 8'($urandom_range(0, 255));
      tgt_r = tr; tgt_g = tg; tgt_b = tb; step_i = 4'($urandom_range(4, 15));
      tgt_valid = 1'b1; sync = 1'b0; psync = 1'b0;
      prev = {rcolor_o, gcolor_o, bcolor_o};
      @(negedge clk);
      tgt_valid = 1'b0;
      while (!fin && cyc < 20000) begin
         sync = ((cyc % 16) < 10);
         rise = sync && !psync;
         psync = sync;
         // a different target offered mid-fade must be ignored
         if (cyc >= 40 && cyc < 45) begin
            tgt_valid = 1'b1; tgt_r = ~tr; tgt_g = tg ^ 8'h55; tgt_b = ~tb;
         end else begin
            tgt_valid = 1'b0;
         end
         @(negedge clk);
         n_vec++;
         if ({rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done} !==
             {m_r[7:0], m_g[7:0], m_b[7:0], (!m_fade && rst), m_fade, m_done}) begin
            n_err++;
            $display("FAIL held_cycle cyc=%0d got=%h exp=%h", cyc,
                     {rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done},
                     {m_r[7:0], m_g[7:0], m_b[7:0], (!m_fade && rst), m_fade, m_done});
         end
         if (cyc >= 40 && cyc < 45) begin
            n_vec++;
            if (tgt_ready !== 1'b0) begin
               n_err++; $display("FAIL held_ready cyc=%0d got=%b exp=0", cyc, tgt_ready);
            end
         end
         if ({rcolor_o, gcolor_o, bcolor_o} !== prev && !rise) begin
            n_vec++; n_err++;
            $display("FAIL held_change_off_tick cyc=%0d got=%h exp=%h", cyc,
                     {rcolor_o, gcolor_o, bcolor_o}, prev);
         end
         prev = {rcolor_o, gcolor_o, bcolor_o};
         cyc++;
         if (done === 1'b1) fin = 1'b1;
      end
      tgt_valid = 1'b0;
      n_vec++;
      if (!fin || {rcolor_o, gcolor_o, bcolor_o} !== {tr, tg, tb}) begin
         n_err++; $display("FAIL held_final got fin=%0d rgb=%h exp fin=1 rgb=%h", fin,
                           {rcolor_o, gcolor_o, bcolor_o}, {tr, tg, tb});
      end
   endtask

   task automatic test_reset_mid();
      bit fin = 1'b0;
      bit dn = 1'b0;
      int cyc = 0;
      tgt_r = far_from(m_r); tgt_g = 8'($urandom_range(0, 255)); tgt_b = 8'($urandom_range(0, 255));
      step_i = 4'($urandom_range(4, 15)); tgt_valid = 1'b1; sync = 1'b0;
      @(negedge clk);
      tgt_valid = 1'b0;
      for (int c = 0; c < 100; c++) begin
         sync = (c % 6 == 0);
         @(negedge clk);
         if (done === 1'b1) dn = 1'b1;
      end
      n_vec++;
      if (busy !== 1'b1 || dn) begin
         n_err++; $display("FAIL rstmid_pre got busy=%b done_seen=%0d exp busy=1 done_seen=0", busy, dn);
      end
      rst = 1'b0; sync = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done} !== 27'h0) begin
         n_err++; $display("FAIL rstmid_hold got=%h exp=%h",
                           {rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done}, 27'h0);
      end
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done} !== {24'h0, 3'b100}) begin
         n_err++; $display("FAIL rstmid_after got=%h exp=%h",
                           {rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done}, {24'h0, 3'b100});
      end
      tgt_r = 8'($urandom_range(0, 255)); tgt_g = 8'($urandom_range(0, 255));
      tgt_b = 8'($urandom_range(0, 255)); step_i = 4'($urandom_range(4, 15));
      tgt_valid = 1'b1;
      @(negedge clk);
      tgt_valid = 1'b0;
      while (!fin && cyc < 5000) begin
         sync = (cyc % 6 == 0);
         @(negedge clk);
         cyc++;
         n_vec++;
         if ({rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done} !==
             {m_r[7:0], m_g[7:0], m_b[7:0], (!m_fade && rst), m_fade, m_done}) begin
            n_err++;
            $display("FAIL rstmid_refade cyc=%0d got=%h exp=%h", cyc,
                     {rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done},
                     {m_r[7:0], m_g[7:0], m_b[7:0], (!m_fade && rst), m_fade, m_done});
         end
         if (done === 1'b1) fin = 1'b1;
      end
      n_vec++;
      if (!fin) begin
         n_err++; $display("FAIL rstmid_timeout got no done exp done within 5000 clks");
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         int per, hi, cyc;
         bit fin;
         per = $urandom_range(3, 8);
         hi  = $urandom_range(1, per - 1);
         cyc = 0; fin = 1'b0;
         tgt_r = 8'($urandom_range(0, 255)); tgt_g = 8'($urandom_range(0, 255));
         tgt_b = 8'($urandom_range(0, 255)); step_i = 4'($urandom_range(0, 15));
         tgt_valid = 1'b1; sync = 1'b0;
         @(negedge clk);
         tgt_valid = 1'b0;
         while (!fin && cyc < 10000) begin
            sync = ((cyc % per) < hi);
            @(negedge clk);
            cyc++;
            n_vec++;
            if ({rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done} !==
                {m_r[7:0], m_g[7:0], m_b[7:0], (!m_fade && rst), m_fade, m_done}) begin
               n_err++;
               $display("FAIL random it=%0d cyc=%0d got=%h exp=%h", it, cyc,
                        {rcolor_o, gcolor_o, bcolor_o, tgt_ready, busy, done},
                        {m_r[7:0], m_g[7:0], m_b[7:0], (!m_fade && rst), m_fade, m_done});
            end
            if (done === 1'b1) fin = 1'b1;
         end
         n_vec++;
         if (!fin) begin
            n_err++; $display("FAIL random_timeout it=%0d got no done exp done", it);
         end
      end
   endtask

   initial begin
      rst = 1'b0; sync = 1'b0; tgt_valid = 1'b0;
      tgt_r = 8'd0; tgt_g = 8'd0; tgt_b = 8'd0; step_i = 4'd0;
      @(negedge clk);
      test_reset();
      test_idle_sync();
      test_fade_basic();
      test_step_zero();
      test_equal_target();
      test_held_sync();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog got no completion exp finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
